// File: rtl/key_expansion_256_ctrl_if.sv
// rtl/key_expansion_256_ctrl_if.sv - request/response bundle for the AES-256 key schedule sequencer
// Signals:
//   start    - one-cycle request to load key and expand (master -> slave)
//   key      - 256-bit cipher key, key[255:224] is w0 (master -> slave)
//   busy     - expansion in progress (slave -> master)
//   done     - all 60 words written, held until next accepted start (slave -> master)
//   rk_idx   - round-key index 0..14 (master -> slave)
//   rk_out   - registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]} (slave -> master)
//   rk_valid - registered, all four words of the round belong to the current key (slave -> master)
//   zeroize  - clear all key material, only when KEYEXP_ZEROIZE_EN is defined (master -> slave)
interface key_expansion_256_ctrl_if;
    logic         start;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
`ifdef KEYEXP_ZEROIZE_EN
    logic         zeroize;

    modport master (output start, key, rk_idx, zeroize, input busy, done, rk_out, rk_valid);
    modport slave  (input start, key, rk_idx, zeroize, output busy, done, rk_out, rk_valid);
`else
    modport master (output start, key, rk_idx, input busy, done, rk_out, rk_valid);
    modport slave  (input start, key, rk_idx, output busy, done, rk_out, rk_valid);
`endif
endinterface

// File: rtl/key_expansion_256_ctrl.sv
// rtl/key_expansion_256_ctrl.sv - AES-256 key schedule sequencer with per-round availability
// Optional feature macro: KEYEXP_ZEROIZE_EN (adds bus.zeroize, clears all key material).
// Modules:
//   current_word_gen_256   - combinational generator for one schedule word w[i]
//     i_i[5:0], prev_word_i (w[i-1]), prev_period_word_i (w[i-8]) -> word_o (w[i])
//   key_expansion_256_ctrl - top
//     clk, rst_n (asynchronous active-low), bus (key_expansion_256_ctrl_if.slave)

module current_word_gen_256 (
    input  logic [5:0]  i_i,
    input  logic [31:0] prev_word_i,
    input  logic [31:0] prev_period_word_i,
    output logic [31:0] word_o
);
    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, maps 0 to 0) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] sub_w;
    logic [31:0] rot_sub;
    logic [31:0] temp;
    logic [7:0]  rcon;

    always_comb begin
        sub_w   = {sbox(prev_word_i[31:24]), sbox(prev_word_i[23:16]),
                   sbox(prev_word_i[15:8]),  sbox(prev_word_i[7:0])};
        // SubWord commutes with RotWord, so one set of S-boxes serves both paths
        rot_sub = {sub_w[23:0], sub_w[31:24]};
        rcon    = 8'h01 << (i_i[5:3] - 3'd1);
        case (i_i[2:0])
            3'd0:    temp = rot_sub ^ {rcon, 24'h000000};
            3'd4:    temp = sub_w;
            default: temp = prev_word_i;
        endcase
        word_o = prev_period_word_i ^ temp;
    end
endmodule

module key_expansion_256_ctrl (
    input  logic                           clk,
    input  logic                           rst_n,
    key_expansion_256_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state_q, state_d;
    logic [5:0]   i_q, i_d;
    logic [5:0]   wr_cnt_q, wr_cnt_d;
    logic [31:0]  window_q [8];   // [0] oldest = w[i-8], [7] newest = w[i-1]
    logic [31:0]  store_q [60];
    logic [127:0] rk_out_q, rk_out_d;
    logic         rk_valid_q, rk_valid_d;
    logic         load, step, clear;
    logic [31:0]  gen_word;
    logic         rd_ok;
    logic [5:0]   rd_base;
    logic [6:0]   rd_need;

    current_word_gen_256 u_gen (
        .i_i                (i_q),
        .prev_word_i        (window_q[7]),
        .prev_period_word_i (window_q[0]),
        .word_o             (gen_word)
    );

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        wr_cnt_d = wr_cnt_q;
        load     = 1'b0;
        step     = 1'b0;
        clear    = 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
        if (bus.zeroize) begin
            clear    = 1'b1;
            state_d  = IDLE;
            i_d      = 6'd0;
            wr_cnt_d = 6'd0;
        end else
`endif
        begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        load     = 1'b1;
                        state_d  = EXPAND;
                        i_d      = 6'd8;
                        wr_cnt_d = 6'd8;
                    end
                end
                EXPAND: begin
                    step     = 1'b1;
                    i_d      = i_q + 6'd1;
                    wr_cnt_d = wr_cnt_q + 6'd1;
                    if (i_q == 6'd59) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Availability uses the pre-edge word count, so a round whose last word lands
    // on this edge reads back invalid now and valid one cycle later.
    always_comb begin
        rd_ok      = (bus.rk_idx != 4'd15);
        rd_base    = rd_ok ? {bus.rk_idx, 2'b00} : 6'd0;
        rd_need    = {1'b0, bus.rk_idx, 2'b00} + 7'd4;
        rk_out_d   = 128'd0;
        rk_valid_d = 1'b0;
        if (rd_ok && !clear) begin
            rk_out_d   = {store_q[rd_base], store_q[rd_base + 6'd1],
                          store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
            rk_valid_d = ({1'b0, wr_cnt_q} >= rd_need);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            i_q        <= 6'd0;
            wr_cnt_q   <= 6'd0;
            rk_out_q   <= 128'd0;
            rk_valid_q <= 1'b0;
            for (int k = 0; k < 8; k++) window_q[k] <= 32'd0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            wr_cnt_q   <= wr_cnt_d;
            rk_out_q   <= rk_out_d;
            rk_valid_q <= rk_valid_d;
            if (clear) begin
                for (int k = 0; k < 8; k++) window_q[k] <= 32'd0;
            end else if (load) begin
                for (int k = 0; k < 8; k++) window_q[k] <= bus.key[255 - 32*k -: 32];
            end else if (step) begin
                for (int k = 0; k < 7; k++) window_q[k] <= window_q[k + 1];
                window_q[7] <= gen_word;
            end
        end
    end

    // Schedule store carries no reset; rk_valid masks whatever it holds.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int k = 0; k < 60; k++) store_q[k] <= 32'd0;
        end else if (load) begin
            for (int k = 0; k < 8; k++) store_q[k] <= bus.key[255 - 32*k -: 32];
        end else if (step) begin
            store_q[i_q] <= gen_word;
        end
    end

    assign bus.busy     = (state_q == EXPAND);
    assign bus.done     = (state_q == DONE);
    assign bus.rk_out   = rk_out_q;
    assign bus.rk_valid = rk_valid_q;
endmodule

// File: tb/tb_key_expansion_256_ctrl.sv
// tb/tb_key_expansion_256_ctrl.sv - self-checking bench for key_expansion_256_ctrl
module tb_key_expansion_256_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_expansion_256_ctrl_if bus();
    key_expansion_256_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [127:0] rk;
        logic [127:0] mask;
        logic         v;
        string        name;
    } sb_t;

    typedef struct {
        logic [255:0] key;
        logic [3:0]   idx;
        logic [127:0] rk;
        logic [127:0] mask;
        logic         v;
        string        name;
    } vec_t;

    localparam logic [255:0] KA3  = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [255:0] KSEQ = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam int NV = 8;

    int           checks = 0;
    int           errors = 0;
    sb_t          sb_q[$];
    vec_t         vecs [NV];
    logic [127:0] sbox_rows [16];
    logic [7:0]   rcon_tab [8];
    logic [31:0]  ref_w [60];
    logic [31:0]  m_w [60];
    int           m_cnt;
    bit           m_busy;

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        int lo;
        row = sbox_rows[x[7:4]];
        lo  = 8 * (15 - int'(x[3:0]));
        return row[lo +: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    task automatic calc(input logic [255:0] k);
        logic [31:0] t;
        for (int j = 0; j < 8; j++) ref_w[j] = k[255 - 32*j -: 32];
        for (int j = 8; j < 60; j++) begin
            t = ref_w[j-1];
            if (j % 8 == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[j/8], 24'h000000};
            else if (j % 8 == 4) t = subw(t);
            ref_w[j] = ref_w[j-8] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    function automatic logic [127:0] m_rk(input int r);
        return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge; the reference model follows the same edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
`ifdef KEYEXP_ZEROIZE_EN
            if (bus.zeroize) begin
                m_busy = 0;
                m_cnt  = 0;
                for (int j = 0; j < 60; j++) m_w[j] = 32'd0;
            end else
`endif
            if (bus.start && !m_busy) begin
                calc(bus.key);
                m_w    = ref_w;
                m_cnt  = 8;
                m_busy = 1;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == 60) m_busy = 0;
            end
        end
        #1;
    endtask

    task automatic do_start(input logic [255:0] k);
        @(negedge clk);
        bus.key   = k;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic read_cycle(input logic [3:0] idx, input logic [127:0] rk, input logic [127:0] mask,
                              input logic v, input string name);
        sb_t e;
        @(negedge clk);
        bus.rk_idx = idx;
        e.rk = rk; e.mask = mask; e.v = v; e.name = name;
        sb_q.push_back(e);
        tick();
        e = sb_q.pop_front();
        chk({e.name, "_valid"}, {127'd0, bus.rk_valid}, {127'd0, e.v});
        chk({e.name, "_data"}, bus.rk_out & e.mask, e.rk & e.mask);
    endtask

    task automatic model_read(input logic [3:0] idx, input string name);
        logic         v;
        logic [127:0] rk;
        logic [127:0] mask;
        if (idx > 4'd14) begin
            v = 1'b0; rk = '0; mask = '1;
        end else begin
            v    = (m_cnt >= 4*int'(idx) + 4);
            rk   = m_rk(int'(idx));
            mask = v ? '1 : '0;
        end
        read_cycle(idx, rk, mask, v, name);
    endtask

    task automatic set_vec(input int t, input logic [255:0] k, input logic [3:0] idx, input logic [127:0] rk,
                           input logic [127:0] mask, input logic v, input string name);
        vecs[t].key = k; vecs[t].idx = idx; vecs[t].rk = rk;
        vecs[t].mask = mask; vecs[t].v = v; vecs[t].name = name;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [255:0] kv;
        logic [255:0] rkey;

        sbox_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        sbox_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        sbox_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
        sbox_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
        sbox_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
        sbox_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
        sbox_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
        sbox_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
        sbox_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
        sbox_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
        sbox_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
        sbox_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
        sbox_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
        sbox_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
        sbox_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
        sbox_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
        rcon_tab[0] = 8'h00; rcon_tab[1] = 8'h01; rcon_tab[2] = 8'h02; rcon_tab[3] = 8'h04;
        rcon_tab[4] = 8'h08; rcon_tab[5] = 8'h10; rcon_tab[6] = 8'h20; rcon_tab[7] = 8'h40;

        rst_n = 1'b0; bus.start = 1'b0; bus.key = '0; bus.rk_idx = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
        bus.zeroize = 1'b0;
`endif
        m_cnt = 0; m_busy = 0;
        for (int j = 0; j < 60; j++) m_w[j] = 32'd0;

        // Vector table: expansion to done, then one read
        kv = KA3;
        calc(KA3);
        set_vec(0, KA3, 4'd2, {32'h9ba35411, 96'h0}, {32'hffffffff, 96'h0}, 1'b1, "a3_w8");
        set_vec(1, KA3, 4'd3, {32'ha8b09c1a, 96'h0}, {32'hffffffff, 96'h0}, 1'b1, "a3_w12");
        set_vec(2, KA3, 4'd14, {96'h0, 32'h706c631e}, {96'h0, 32'hffffffff}, 1'b1, "a3_w59");
        set_vec(3, KA3, 4'd0, kv[255:128], '1, 1'b1, "a3_r0");
        set_vec(4, KSEQ, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, '1, 1'b1, "seq_r14");
        set_vec(5, KSEQ, 4'd15, 128'h0, '1, 1'b0, "seq_idx15");
        rkey = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        calc(rkey);
        set_vec(6, rkey, 4'd7, ref_rk(7), '1, 1'b1, "rand_r7");
        set_vec(7, rkey, 4'd1, ref_rk(1), '1, 1'b1, "rand_r1");

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {127'd0, bus.busy}, 128'd0);
        chk("rst_done", {127'd0, bus.done}, 128'd0);
        chk("rst_rk_valid", {127'd0, bus.rk_valid}, 128'd0);
        chk("rst_rk_out", bus.rk_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < NV; t++) begin
            do_start(vecs[t].key);
            chk({vecs[t].name, "_busy"}, {127'd0, bus.busy}, 128'd1);
            wait_done(n);
            chk({vecs[t].name, "_done_lat"}, 128'(n), 128'd52);
            read_cycle(vecs[t].idx, vecs[t].rk, vecs[t].mask, vecs[t].v, vecs[t].name);
        end

        // Poll round 5 from the first edge after acceptance
        do_start(KSEQ);
        for (int k = 1; k <= 30; k++) model_read(4'd5, "poll_r5");
        wait_done(n);
        chk("poll_done_lat", 128'(30 + n), 128'd52);

        // Start pulse on the 20th edge of EXPAND is ignored
        do_start(KA3);
        repeat (19) tick();
        do_start(KSEQ);
        wait_done(n);
        chk("ign_done_lat", 128'(20 + n), 128'd52);
        read_cycle(4'd14, {96'h0, 32'h706c631e}, {96'h0, 32'hffffffff}, 1'b1, "ign_w59");
        model_read(4'd8, "ign_r8");

        // Reset during EXPAND
        do_start(KSEQ);
        repeat (30) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {127'd0, bus.busy}, 128'd0);
        chk("abort_done", {127'd0, bus.done}, 128'd0);
        chk("abort_rk_valid", {127'd0, bus.rk_valid}, 128'd0);
        chk("abort_rk_out", bus.rk_out, 128'd0);
        m_busy = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_read(4'd0, "post_rst_r0");
        chk("post_rst_done", {127'd0, bus.done}, 128'd0);
        rkey = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        do_start(rkey);
        wait_done(n);
        chk("rerun_done_lat", 128'(n), 128'd52);
        model_read(4'd9, "rerun_r9");
        model_read(4'd3, "rerun_r3");

`ifdef KEYEXP_ZEROIZE_EN
        // Zeroize together with start in DONE
        @(negedge clk);
        bus.zeroize = 1'b1; bus.start = 1'b1; bus.key = KA3; bus.rk_idx = 4'd0;
        tick();
        bus.zeroize = 1'b0; bus.start = 1'b0;
        chk("zero_busy", {127'd0, bus.busy}, 128'd0);
        chk("zero_done", {127'd0, bus.done}, 128'd0);
        chk("zero_rk_out", bus.rk_out, 128'd0);
        chk("zero_rk_valid", {127'd0, bus.rk_valid}, 128'd0);
        read_cycle(4'd0, 128'd0, '1, 1'b0, "zero_r0");
        repeat (3) tick();
        chk("zero_start_ignored", {127'd0, bus.busy}, 128'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
